// File: rtl/ft_error_logger.sv
// Error logger for the fault-tolerance manager: counts rising edges of error_i,
// logs the matching ID-stage PC in a FIFO, and exposes both over a data-port slave.
module ft_error_logger #(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        error_i,
    input  logic [31:0] pc_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_be_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        irq_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_LEVEL  = 2'd1;
    localparam logic [1:0] ADDR_POP    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    logic                 err_q;
    logic [CNT_WIDTH-1:0] count;
    logic                 overflow;
    logic [LW-1:0]        level;
    logic [LW-1:0]        level_next;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 irq_en;
    logic [31:0]          mem [DEPTH];

    logic [1:0]  addr_sel;
    logic        rd_req;
    logic        wr_req;
    logic        err_edge;
    logic        clr;
    logic        pop_do;
    logic        push_ev;
    logic        push_do;
    logic        full;
    logic        drop;
    logic        irq_en_next;
    logic [31:0] status_word;
    logic [31:0] rdata_next;
    logic        unused_inputs;

    // Byte enables and the undecoded address/data bits have no effect.
    assign unused_inputs = ^{data_be_i, data_addr_i[31:4], data_addr_i[1:0],
                             data_wdata_i[31:2]};

    assign data_gnt_o = data_req_i;
    assign addr_sel   = data_addr_i[3:2];
    assign rd_req     = data_req_i & ~data_we_i;
    assign wr_req     = data_req_i & data_we_i;

    assign err_edge = error_i & ~err_q;
    assign clr      = wr_req & (addr_sel == ADDR_CTRL) & data_wdata_i[1];
    assign full     = (level == LW'(DEPTH));

    // A pop frees a slot in the same cycle, so a push into a full FIFO still fits.
    assign pop_do  = rd_req & (addr_sel == ADDR_POP) & (level != '0);
    assign push_ev = err_edge & ~clr;
    assign push_do = push_ev & (~full | pop_do);
    assign drop    = push_ev & full & ~pop_do;

    assign irq_en_next = (wr_req && addr_sel == ADDR_CTRL) ? data_wdata_i[0] : irq_en;

    always_comb begin
        level_next = level;
        if (clr) begin
            level_next = '0;
        end else begin
            case ({push_do, pop_do})
                2'b10:   level_next = level + 1'b1;
                2'b01:   level_next = level - 1'b1;
                default: level_next = level;
            endcase
        end
    end

    always_comb begin
        status_word                = '0;
        status_word[CNT_WIDTH-1:0] = count;
        status_word[31]            = overflow;
    end

    always_comb begin
        rdata_next = '0;
        if (rd_req) begin
            case (addr_sel)
                ADDR_STATUS: rdata_next = status_word;
                ADDR_LEVEL:  rdata_next = {27'b0, 5'(level)};
                ADDR_POP:    rdata_next = (level != '0) ? mem[rd_ptr] : 32'hFFFF_FFFF;
                default:     rdata_next = {31'b0, irq_en};
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_do) begin
            mem[wr_ptr] <= pc_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q         <= 1'b0;
            count         <= '0;
            overflow      <= 1'b0;
            level         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            irq_en        <= 1'b0;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            irq_o         <= 1'b0;
        end else begin
            err_q         <= error_i;
            irq_en        <= irq_en_next;
            level         <= level_next;
            data_rvalid_o <= data_req_i;
            data_rdata_o  <= rdata_next;
            irq_o         <= irq_en & (level_next != '0);

            if (clr) begin
                count    <= '0;
                overflow <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (push_ev && count != '1) begin
                    count <= count + 1'b1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                if (push_do) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop_do) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ft_error_logger.sv
// Scoreboard bench for ft_error_logger: the driver queues expected read data,
// a negedge monitor compares each rvalid beat against the queue head.
module tb_ft_error_logger;

    logic        clk = 1'b0;
    logic        rst;
    logic        error;
    logic [31:0] pc;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;

    logic        gnt, rvalid, irq;
    logic [31:0] rdata;
    logic        sat_gnt, sat_rvalid, sat_irq;
    logic [31:0] sat_rdata;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] sat_exp;
        bit          sat_chk;
        int          tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   tag_cnt  = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    ft_error_logger #(.DEPTH(8), .CNT_WIDTH(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .error_i(error), .pc_i(pc),
        .data_req_i(req), .data_we_i(we), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_be_i(be),
        .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_rdata_o(rdata),
        .irq_o(irq)
    );

    // Narrow counter and shallow FIFO so saturation is reachable quickly.
    ft_error_logger #(.DEPTH(2), .CNT_WIDTH(4)) u_sat (
        .clk_i(clk), .rst_i(rst), .error_i(error), .pc_i(pc),
        .data_req_i(req), .data_we_i(we), .data_addr_i(addr),
        .data_wdata_i(wdata), .data_be_i(be),
        .data_gnt_o(sat_gnt), .data_rvalid_o(sat_rvalid), .data_rdata_o(sat_rdata),
        .irq_o(sat_irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            req_prev <= 1'b0;
        end else begin
            chk("gnt", 32'(gnt), 32'(req));
            chk("rvalid_timing", 32'(rvalid), 32'(req_prev));
            if (rvalid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rvalid: got rdata %h expected no response", rdata);
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("rdata#%0d", mon_e.tag), rdata, mon_e.exp);
                    if (mon_e.sat_chk)
                        chk($sformatf("sat_rdata#%0d", mon_e.tag), sat_rdata, mon_e.sat_exp);
                end
            end
            req_prev <= req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] exp, input logic [31:0] sexp, input bit sc);
        exp_t e;
        e.exp     = exp;
        e.sat_exp = sexp;
        e.sat_chk = sc;
        e.tag     = tag_cnt++;
        sb.push_back(e);
    endtask

    task automatic set_rd(input logic [1:0] a);
        req  = 1'b1;
        we   = 1'b0;
        addr = {28'b0, a, 2'b00};
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        set_rd(a);
        push_exp(exp, 32'h0, 1'b0);
        tick();
        req = 1'b0;
    endtask

    task automatic rd2(input logic [1:0] a, input logic [31:0] exp, input logic [31:0] sexp);
        set_rd(a);
        push_exp(exp, sexp, 1'b1);
        tick();
        req = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = 1'b1;
        addr  = {28'b0, a, 2'b00};
        wdata = d;
        push_exp(32'h0, 32'h0, 1'b0);
        tick();
        req   = 1'b0;
        we    = 1'b0;
        wdata = 32'h0;
    endtask

    task automatic pulse(input logic [31:0] p);
        error = 1'b1;
        pc    = p;
        tick();
        error = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; error = 1'b0; pc = '0; req = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; be = 4'hF;
        tick(); tick();
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        tick();

        // Held-high error is a single event.
        error = 1'b1; pc = 32'h40;
        repeat (5) tick();
        error = 1'b0;
        tick();
        rd(2'd0, 32'h0000_0001);
        rd(2'd1, 32'd1);
        rd(2'd2, 32'h0000_0040);
        rd(2'd1, 32'd0);

        // Ten events into an 8-deep FIFO: two dropped, overflow sticky.
        wr(2'd3, 32'h2);
        for (int i = 0; i < 10; i++) pulse(32'h10 + 32'(4 * i));
        rd(2'd0, 32'h8000_000A);
        rd(2'd1, 32'd8);
        for (int i = 0; i < 8; i++) rd(2'd2, 32'h10 + 32'(4 * i));
        rd(2'd2, 32'hFFFF_FFFF);
        rd(2'd1, 32'd0);

        // Full FIFO with pop and push in the same cycle.
        wr(2'd3, 32'h2);
        for (int i = 0; i < 8; i++) pulse(32'h60 + 32'(4 * i));
        set_rd(2'd2);
        push_exp(32'h60, 32'h0, 1'b0);
        error = 1'b1; pc = 32'h88;
        tick();
        req = 1'b0; error = 1'b0;
        tick();
        rd(2'd0, 32'h0000_0009);
        rd(2'd1, 32'd8);
        for (int i = 1; i < 8; i++) rd(2'd2, 32'h60 + 32'(4 * i));
        rd(2'd2, 32'h88);
        rd(2'd1, 32'd0);

        // Empty FIFO with pop and push in the same cycle.
        set_rd(2'd2);
        push_exp(32'hFFFF_FFFF, 32'h0, 1'b0);
        error = 1'b1; pc = 32'hB0;
        tick();
        req = 1'b0; error = 1'b0;
        tick();
        rd(2'd1, 32'd1);
        rd(2'd2, 32'hB0);

        // Interrupt rise/fall, then clear colliding with an event.
        wr(2'd3, 32'h1);
        error = 1'b1; pc = 32'h90;
        chk("irq_before_push", 32'(irq), 32'h0);
        tick();
        chk("irq_after_push", 32'(irq), 32'h1);
        error = 1'b0;
        tick();
        set_rd(2'd2);
        push_exp(32'h90, 32'h0, 1'b0);
        tick();
        req = 1'b0;
        chk("irq_after_pop", 32'(irq), 32'h0);
        pulse(32'hA4);
        chk("irq_pending", 32'(irq), 32'h1);
        req = 1'b1; we = 1'b1; addr = 32'hC; wdata = 32'h3;
        push_exp(32'h0, 32'h0, 1'b0);
        error = 1'b1; pc = 32'hA8;
        tick();
        req = 1'b0; we = 1'b0; wdata = 32'h0; error = 1'b0;
        chk("irq_after_clear", 32'(irq), 32'h0);
        tick();
        rd(2'd0, 32'h0);
        rd(2'd1, 32'd0);
        rd(2'd3, 32'h1);

        // Saturation on the 4-bit counter instance.
        wr(2'd3, 32'h2);
        for (int i = 0; i < 20; i++) pulse(32'h100 + 32'(4 * i));
        rd2(2'd0, 32'h8000_0014, 32'h8000_000F);
        rd2(2'd1, 32'd8, 32'd2);

        // Back-to-back reads, then reset with an rvalid pending.
        wr(2'd3, 32'h1);
        rd(2'd0, 32'h8000_0014);
        rd(2'd1, 32'd8);
        rd(2'd3, 32'h1);
        chk("irq_before_reset", 32'(irq), 32'h1);
        set_rd(2'd0);
        tick();
        rst = 1'b1; req = 1'b0;
        #1;
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        rd(2'd0, 32'h0);
        rd(2'd1, 32'd0);
        rd(2'd3, 32'h0);
        rd(2'd2, 32'hFFFF_FFFF);

        tick(); tick(); tick();
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ft_error_logger.md
Name: ft_error_logger

Overview:
- Memory-mapped error logger on the consumer side of the fault-tolerance manager's error signal.
- Counts detected lockstep errors and captures the core_0 ID-stage PC of each error into a FIFO.
- Software on the core reads the results back over a data-port slave interface (req/gnt/rvalid).
- Sits beside data_mem on the SoC data bus; raises an interrupt while logged entries are pending.

Parameters:
- DEPTH, 8, number of PC log entries; power of two, 2..16.
- CNT_WIDTH, 16, width of the saturating error counter; at most 31.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- error_i  in  1  FTM error flag; level signal, may stay high for several cycles
- pc_i  in  32  PC of the instruction in ID, sampled with error_i
- data_req_i  in  1  bus request
- data_we_i  in  1  write enable
- data_addr_i  in  32  byte address; only bits [3:2] are decoded
- data_wdata_i  in  32  write data
- data_be_i  in  4  byte enables; ignored, all accesses are treated as full-word
- data_gnt_o  out  1  grant
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  32  read data
- irq_o  out  1  error-pending interrupt

Behaviour:
- Reset (async, rst_i=1): count=0, overflow=0, FIFO empty, irq_en=0, error_i edge register=0, data_rvalid_o=0, data_rdata_o=0, irq_o=0.
- Event: rising edge of error_i only (error_i=1 and previous-cycle error_i=0). A held-high error_i is one event.
- On an event, pc_i from that same cycle is pushed.
- Count increments by 1 per event and saturates at all-ones; no wrap.
- If the FIFO is full and no pop happens that cycle: entry is dropped, overflow set (sticky), count still increments.
- data_gnt_o = data_req_i, combinational; every request is accepted.
- data_rvalid_o is high exactly one cycle after each granted request, reads and writes alike.
- data_rdata_o is valid in that rvalid cycle and 0 for writes.
- Back-to-back requests give back-to-back rvalids.
- Register map (addr[3:2]):
  - 0 STATUS (RO): [CNT_WIDTH-1:0]=count, [31]=overflow, others 0.
  - 1 LEVEL (RO): [4:0]=FIFO occupancy 0..DEPTH.
  - 2 POP (RO): read returns the oldest PC and pops it. Read when empty returns 0xFFFF_FFFF with no state change.
  - 3 CTRL (RW): bit0=irq_en (readable). Writing 1 to bit1 clears count and overflow and flushes the FIFO (self-clearing, reads 0). Writes to bits 31:2 are ignored.
- Writes to STATUS, LEVEL and POP are ignored; they still produce rvalid.
- Pop/state update happens on the grant cycle. Data is registered and presented with rvalid.
- Push and pop in the same cycle: both performed, level unchanged.
- Full + pop + push in the same cycle: push accepted, no overflow.
- Empty + push + pop in the same cycle: pop returns 0xFFFF_FFFF. The new entry stays, level=1.
- Clear and event in the same cycle: clear wins; the event is discarded entirely (no count, no push).
- FIFO pointers wrap modulo DEPTH. Full/empty are resolved by occupancy counter, not pointer compare.
- irq_o is registered: irq_o <= irq_en & (level_next != 0).
- Reset mid-transaction: a pending rvalid is cancelled (rvalid=0 after reset). No partial state survives.

Test Plan:
- Reset, then error_i high for 5 cycles with pc_i=0x40 -> STATUS reads 0x0000_0001; LEVEL=1; POP returns 0x0000_0040; LEVEL then 0.
- 10 separate error pulses with pc_i=0x10,0x14,..,0x34, DEPTH=8 -> STATUS=0x8000_000A; LEVEL=8; POP x8 returns 0x10..0x2C in order; ninth POP returns 0xFFFF_FFFF.
- FIFO full, then a POP request in the same cycle as an error edge with pc_i=0x88 -> no overflow set; LEVEL stays 8; last entry popped later is 0x88.
- Write CTRL=0x1, then one error edge -> irq_o rises 1 cycle after the push. POP -> irq_o falls 1 cycle after. Write CTRL=0x3 in the same cycle as an error edge -> STATUS=0, LEVEL=0, irq_o=0, irq_en=1.
- Force count to all-ones (2^CNT_WIDTH-1 pulses, or CNT_WIDTH=4 with 20 pulses) -> STATUS count field stays 0xF; no wrap.
- Back-to-back reads of STATUS, LEVEL, CTRL on consecutive cycles -> gnt the same cycle each time; rvalid on 3 consecutive cycles with correct data. Assert rst_i while an rvalid is pending -> rvalid=0 and all registers return to reset values.
